strobe_gen: RTL and testbench
=============================

// Module: strobe_gen
// PURPOSE
//  Programmable enable-strobe generator driving the en input of enabled D flip-flop
//  stages (dff_en and dff_en-based registers/shifters). Emits one-cycle en pulses
//  every P clocks, either continuously or as a counted burst, with start/stop control
//  and busy/done status. Sits directly upstream of the dff_en datapath.
// PARAMETERS
//  DIV_W  8  width of div (period) input and phase counter
//  CNT_W  8  width of burst_len input and pulse_cnt output
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      level-sampled; begins a run when state is IDLE
//  stop       in   1      aborts a run; priority over every other event
//  mode       in   1      0 = continuous, 1 = burst of burst_len pulses
//  div        in   DIV_W  strobe period P = max(div,1) clocks; latched at start
//  burst_len  in   CNT_W  pulses per burst (mode 1); latched at start
//  en_out     out  1      registered one-cycle enable strobe to dff_en stages
//  busy       out  1      high in RUN and DONE states
//  done       out  1      one-cycle pulse when a burst completes normally
//  pulse_cnt  out  CNT_W  pulses issued in the current/last run; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - One clock, clk; async active-low rst_n. Reset: state IDLE, en_out=0, busy=0,
//    done=0, pulse_cnt=0, phase ph=0, latched div/len/mode=0. Outputs all registered.
//  - States IDLE -> RUN -> DONE -> IDLE; stop from RUN/DONE -> IDLE.
//  - IDLE: start=1 && stop=0 at edge E0 -> RUN; latch P=max(div,1), len, mode;
//    ph<=P-1; pulse_cnt<=0. start&&stop together -> stay IDLE.
//  - RUN, each edge: ph==0 -> en_out<=1, ph<=P-1, pulse_cnt<=pulse_cnt+1;
//    else en_out<=0, ph<=ph-1. First strobe high in cycle after edge E0+P,
//    then every P cycles; P=1 (div 0 or 1) -> en_out high every cycle.
//  - Burst (mode 1): on the edge that issues pulse number len, state<=DONE.
//    DONE edge: done<=1 for one cycle, en_out<=0, -> IDLE. len=0 -> no pulse:
//    RUN->DONE on first RUN edge, done one cycle later, pulse_cnt stays 0.
//  - Continuous (mode 0): runs until stop; pulse_cnt wraps 2^CNT_W-1 -> 0, no event.
//  - stop=1 at any edge in RUN/DONE: -> IDLE, en_out<=0, done<=0, pulse_cnt holds
//    (frozen until next start). stop wins over a same-edge terminal pulse (no pulse).
//  - start while busy ignored; div/burst_len/mode changes mid-run ignored.
//  - rst_n asserted mid-run: immediate return to reset values, no done, no strobe.
// STRUCTURE
//  - Shared package: state encoding (ST_IDLE, ST_RUN, ST_DONE), mode constants
//    (MODE_CONT=0, MODE_BURST=1).
//  - One sub-module: strobe_phase_cnt (DIV_W down-counter with load P-1, terminal
//    flag at 0, reload on terminal); FSM, burst counter and outputs stay in top.
// TESTING
//  - Reset: rst_n=0 mid-stream -> en_out=busy=done=0, pulse_cnt=0 same cycle (async).
//  - mode=0, div=4, start 1 cycle -> en_out high 1 cycle at 4, 8, 12 cycles after
//    start edge; stop after 3rd -> busy=0 next cycle, pulse_cnt=3 held.
//  - mode=1, div=2, burst_len=5 -> 5 strobes spaced 2 cycles, done 1 cycle after
//    5th strobe's edge, busy drops with done, pulse_cnt=5.
//  - div=0 and div=1, mode=1, burst_len=3 -> en_out high 3 consecutive cycles,
//    then done; burst_len=0 -> no strobe, done 2 cycles after start edge.
//  - Edge cases: start&&stop in IDLE -> stays idle; stop on terminal-pulse edge ->
//    no strobe, no done; start during RUN with new div=7 -> period unchanged.
//  - Chain into dff_en: d toggling, en=en_out, div=3 -> q updates only on edges
//    where en_out high; q stable otherwise.

Source files
------------

// File: rtl/strobe_gen_pkg.sv
// Shared constants for the strobe generator: FSM state encoding and run modes.
package strobe_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/strobe_gen_if.sv
// Control/status bundle between a strobe_gen master (controller) and the generator.
interface strobe_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] burst_len;
  logic             en_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start, stop, mode, div, burst_len,
    input  en_out, busy, done, pulse_cnt
  );

  modport slave (
    input  start, stop, mode, div, burst_len,
    output en_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/strobe_phase_cnt.sv
// Period down-counter: loads P-1 at run start, flags terminal at zero and
// reloads itself on the terminal count while running.
module strobe_phase_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic [DIV_W-1:0] reload_val_i,
  output logic             term_o
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] ph_q, ph_d;

  assign term_o = (ph_q == '0);

  always_comb begin
    ph_d = ph_q;
    if (load_i) begin
      ph_d = load_val_i;
    end else if (run_i) begin
      ph_d = term_o ? reload_val_i : (ph_q - ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end
endmodule

// File: rtl/strobe_gen.sv
// Programmable enable-strobe generator: one-cycle en pulses every max(div,1)
// clocks, continuous or as a counted burst, with start/stop and busy/done status.
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  strobe_gen_if.slave bus
);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             ph_load, ph_run, ph_term;
  logic [DIV_W-1:0] div_clamped;
  logic [CNT_W-1:0] cnt_inc;

  assign div_clamped = (bus.div == '0) ? DIV_ONE : bus.div;
  assign cnt_inc     = cnt_q + CNT_ONE;

  strobe_phase_cnt #(.DIV_W(DIV_W)) u_phase (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (ph_load),
    .run_i        (ph_run),
    .load_val_i   (div_clamped - DIV_ONE),
    .reload_val_i (per_q - DIV_ONE),
    .term_o       (ph_term)
  );

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    len_d   = len_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    ph_load = 1'b0;
    ph_run  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          per_d   = div_clamped;
          len_d   = bus.burst_len;
          mode_d  = bus.mode;
          cnt_d   = '0;
          ph_load = 1'b1;
        end
      end
      ST_RUN: begin
        // stop outranks everything, including a terminal pulse on this edge
        if (bus.stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (mode_q == MODE_BURST && len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ph_run = 1'b1;
          if (ph_term) begin
            en_d  = 1'b1;
            cnt_d = cnt_inc;
            if (mode_q == MODE_BURST && cnt_inc == len_q) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = !bus.stop;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_CONT;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.en_out    = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = cnt_q;
endmodule

// File: tb/tb_strobe_gen.sv
// Bench for strobe_gen: directed scenarios plus random control traffic against
// an edge-count reference model, with a dff_en stage driven by en_out.
module tb_strobe_gen;
  localparam int DIV_W = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d_r = 1'b0;
  logic q_r;

  int checks = 0;
  int errors = 0;

  // reference model: run described by edges elapsed since the start edge
  bit m_active, m_mode, m_en, m_done;
  int m_t, m_P, m_len, m_cnt;
  bit exp_q;

  strobe_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  strobe_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_r <= 1'b0;
    else if (bus.en_out) q_r <= d_r;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_mode = 0; m_en = 0; m_done = 0;
    m_t = 0; m_P = 1; m_len = 0; m_cnt = 0; exp_q = 0;
  endfunction

  function automatic void model_edge();
    int done_edge;
    if (!m_active) begin
      m_en = 0;
      m_done = 0;
      if (bus.start && !bus.stop) begin
        m_active = 1;
        m_t = 0;
        m_P = (bus.div == 0) ? 1 : int'(bus.div);
        m_len = int'(bus.burst_len);
        m_mode = bus.mode;
        m_cnt = 0;
      end
    end else begin
      m_t++;
      done_edge = (m_len == 0) ? 2 : m_len * m_P + 1;
      if (bus.stop) begin
        m_active = 0; m_en = 0; m_done = 0;
      end else if (m_mode && m_t == done_edge) begin
        m_active = 0; m_en = 0; m_done = 1;
      end else begin
        m_done = 0;
        m_en = (m_t % m_P == 0) && (!m_mode || (m_t / m_P) <= m_len);
        if (m_mode) m_cnt = ((m_t / m_P) < m_len) ? (m_t / m_P) : m_len;
        else m_cnt = (m_t / m_P) % 256;
      end
    end
  endfunction

  task automatic check_all();
    chk("en_out", 32'(bus.en_out), 32'(m_en));
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("pulse_cnt", 32'(bus.pulse_cnt), 32'(m_cnt));
    chk("dff_q", 32'(q_r), 32'(exp_q));
  endtask

  task automatic drive(input bit s, input bit sp, input bit md, input int dv, input int bl);
    bus.start = s;
    bus.stop = sp;
    bus.mode = md;
    bus.div = DIV_W'(dv);
    bus.burst_len = CNT_W'(bl);
  endtask

  task automatic step();
    bit pe, pd;
    pe = m_en;
    pd = d_r;
    @(posedge clk);
    model_edge();
    if (pe) exp_q = pd;
    #1;
    check_all();
    d_r = ~d_r;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_en_out", 32'(bus.en_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pulse_cnt", 32'(bus.pulse_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0);
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // continuous, div=4, stop after the third strobe
    drive(1, 0, 0, 4, 0); step();
    drive(0, 0, 0, 4, 0); repeat (12) step();
    chk("cont_third_strobe", 32'(bus.en_out), 1);
    drive(0, 1, 0, 4, 0); step();
    chk("cont_stop_busy", 32'(bus.busy), 0);
    chk("cont_stop_cnt", 32'(bus.pulse_cnt), 3);
    drive(0, 0, 0, 4, 0); repeat (3) step();
    chk("cont_cnt_held", 32'(bus.pulse_cnt), 3);

    // burst of 5 at div=2
    drive(1, 0, 1, 2, 5); step();
    drive(0, 0, 1, 2, 5); repeat (11) step();
    chk("burst_done", 32'(bus.done), 1);
    chk("burst_busy", 32'(bus.busy), 0);
    chk("burst_cnt", 32'(bus.pulse_cnt), 5);
    repeat (2) step();

    // div 0 and div 1 burst of 3: back-to-back strobes
    for (int dv = 0; dv < 2; dv++) begin
      drive(1, 0, 1, dv, 3); step();
      drive(0, 0, 1, dv, 3); repeat (3) step();
      chk("p1_third_strobe", 32'(bus.en_out), 1);
      step();
      chk("p1_done", 32'(bus.done), 1);
      step();
    end

    // zero-length burst
    drive(1, 0, 1, 3, 0); step();
    drive(0, 0, 1, 3, 0); repeat (2) step();
    chk("len0_done", 32'(bus.done), 1);
    chk("len0_cnt", 32'(bus.pulse_cnt), 0);
    step();

    // start and stop together in idle
    drive(1, 1, 0, 2, 0); step();
    chk("startstop_idle", 32'(bus.busy), 0);
    drive(0, 0, 0, 2, 0); step();

    // stop on the terminal-pulse edge of a burst
    drive(1, 0, 1, 3, 2); step();
    drive(0, 0, 1, 3, 2); repeat (5) step();
    drive(0, 1, 1, 3, 2); step();
    chk("stop_term_en", 32'(bus.en_out), 0);
    chk("stop_term_cnt", 32'(bus.pulse_cnt), 1);
    drive(0, 0, 1, 3, 2); repeat (3) step();
    chk("stop_term_nodone", 32'(bus.done), 0);

    // start with a new div during a run is ignored
    drive(1, 0, 0, 3, 0); step();
    drive(1, 0, 0, 7, 0); repeat (9) step();
    chk("restart_ignored", 32'(bus.pulse_cnt), 3);
    drive(0, 1, 0, 7, 0); step();
    drive(0, 0, 0, 7, 0); step();

    // continuous wrap of pulse_cnt
    drive(1, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 0); repeat (256) step();
    chk("cnt_wrap", 32'(bus.pulse_cnt), 0);
    repeat (3) step();

    // reset mid-run
    async_reset();
    step();
    drive(1, 0, 0, 2, 0); step();
    drive(0, 0, 0, 2, 0); repeat (5) step();
    async_reset();
    repeat (2) step();

    // random control traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 5));
      step();
      if (i % 500 == 499) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
